// File: rtl/tx_zc_pkg.sv
// ============================================================================
// Module   : tx_zc_pkg
// Purpose  : Shared ZC transmit constants, FSM encoding and modulus helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_zc_pkg;

  localparam int unsigned c_ph_width_def  = 16;
  localparam int unsigned c_len_width_def = 13;
  localparam int unsigned c_zc_scale      = 24;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_init = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  // Phase circle size in units of 2*pi/(24*Nzc).
  function automatic logic [31:0] zc_modulus(input logic [10:0] n_zc);
    return 32'(n_zc) * c_zc_scale;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_zc_phase_gen_if.sv
// ============================================================================
// Module   : tx_zc_phase_gen_if
// Purpose  : Configuration, start/status and phase-stream handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_zc_phase_gen_if
  import tx_zc_pkg::*;
#(
  parameter int PH_WIDTH  = c_ph_width_def,
  parameter int LEN_WIDTH = c_len_width_def
);

  logic                 start;
  logic [14:0]          zc_Q;
  logic [15:0]          zc_P;
  logic [10:0]          zc_N_zc;
  logic [LEN_WIDTH-1:0] seq_len;
  logic                 ph_ready;
  logic                 ph_valid;
  logic [PH_WIDTH-1:0]  ph_idx;
  logic                 ph_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, zc_Q, zc_P, zc_N_zc, seq_len, ph_ready,
    input  ph_valid, ph_idx, ph_last, busy, done
  );

  modport slave (
    input  start, zc_Q, zc_P, zc_N_zc, seq_len, ph_ready,
    output ph_valid, ph_idx, ph_last, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/tx_zc_mod_add.sv
// ============================================================================
// Module   : tx_zc_mod_add
// Purpose  : Combinational modular adder, operands assumed below the modulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_zc_mod_add #(
  parameter int PH_WIDTH = 16
) (
  input  wire logic [PH_WIDTH-1:0] i_a,
  input  wire logic [PH_WIDTH-1:0] i_b,
  input  wire logic [PH_WIDTH-1:0] i_mod,
  output logic      [PH_WIDTH-1:0] o_sum
);

  logic [PH_WIDTH:0] w_sum;
  logic [PH_WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = w_sum - {1'b0, i_mod};
  assign o_sum  = (w_sum >= {1'b0, i_mod}) ? w_diff[PH_WIDTH-1:0] : w_sum[PH_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/tx_zc_phase_gen.sv
// ============================================================================
// Module   : tx_zc_phase_gen
// Purpose  : Multiplier-free Zadoff-Chu phase index generator with handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_zc_phase_gen
  import tx_zc_pkg::*;
#(
  parameter int PH_WIDTH  = c_ph_width_def,
  parameter int LEN_WIDTH = c_len_width_def
) (
  input  wire logic          sys_clk,
  input  wire logic          rst_n,
  tx_zc_phase_gen_if.slave   bus
);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [PH_WIDTH-1:0]  r_mod;
  logic [PH_WIDTH-1:0]  r_inc0;
  logic [PH_WIDTH-1:0]  r_inc;
  logic [PH_WIDTH-1:0]  r_ph;
  logic [10:0]          r_m;
  logic [LEN_WIDTH-1:0] r_cnt;

  logic [PH_WIDTH-1:0]  w_mod_calc;
  logic [PH_WIDTH-1:0]  w_q;
  logic [PH_WIDTH-1:0]  w_p;
  logic [PH_WIDTH-1:0]  w_inc0;
  logic [PH_WIDTH-1:0]  w_ph_next;
  logic [PH_WIDTH-1:0]  w_inc_next;
  logic                 w_run;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_wrap;

  assign w_mod_calc = PH_WIDTH'(zc_modulus(bus.zc_N_zc));
  assign w_q        = PH_WIDTH'(bus.zc_Q);
  assign w_p        = PH_WIDTH'(bus.zc_P);

  assign w_run  = (r_state == c_st_run);
  assign w_last = w_run && (r_cnt == bus.seq_len - LEN_WIDTH'(1));
  assign w_xfer = w_run && bus.ph_ready;
  assign w_wrap = (r_m == bus.zc_N_zc - 11'd1);

  tx_zc_mod_add #(.PH_WIDTH(PH_WIDTH)) u_add_inc0 (
    .i_a   (w_q),
    .i_b   (w_p),
    .i_mod (w_mod_calc),
    .o_sum (w_inc0)
  );

  tx_zc_mod_add #(.PH_WIDTH(PH_WIDTH)) u_add_ph (
    .i_a   (r_ph),
    .i_b   (r_inc),
    .i_mod (r_mod),
    .o_sum (w_ph_next)
  );

  tx_zc_mod_add #(.PH_WIDTH(PH_WIDTH)) u_add_inc (
    .i_a   (r_inc),
    .i_b   (w_q),
    .i_mod (r_mod),
    .o_sum (w_inc_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (bus.start) w_state_nxt = c_st_init;
      c_st_init: w_state_nxt = c_st_run;
      c_st_run:  if (w_xfer && w_last) w_state_nxt = c_st_done;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase/increment recurrence; the period wrap reloads the m=0 state so
  // the cyclic extension continues without a bubble.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mod  <= '0;
      r_inc0 <= '0;
      r_inc  <= '0;
      r_ph   <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
    end else if (r_state == c_st_init) begin
      r_mod  <= w_mod_calc;
      r_inc0 <= w_inc0;
      r_inc  <= w_inc0;
      r_ph   <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + LEN_WIDTH'(1);
      if (w_wrap) begin
        r_ph  <= '0;
        r_inc <= r_inc0;
        r_m   <= '0;
      end else begin
        r_ph  <= w_ph_next;
        r_inc <= w_inc_next;
        r_m   <= r_m + 11'd1;
      end
    end
  end

  assign bus.ph_valid = w_run;
  assign bus.ph_idx   = r_ph;
  assign bus.ph_last  = w_last;
  assign bus.busy     = (r_state != c_st_idle);
  assign bus.done     = (r_state == c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_tx_zc_phase_gen.sv
// ============================================================================
// Module   : tb_tx_zc_phase_gen
// Purpose  : Directed and randomized self-checking bench for tx_zc_phase_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_zc_phase_gen;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   exp_q[$];

  always #5 sys_clk = ~sys_clk;

  tx_zc_phase_gen_if #(.PH_WIDTH(16), .LEN_WIDTH(13)) bus ();

  tx_zc_phase_gen #(.PH_WIDTH(16), .LEN_WIDTH(13)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int zc_ph(input int nzc, input int q, input int p, input int m);
    longint unsigned lm = longint'(m);
    longint unsigned v  = longint'(q) * lm * (lm + 1) / 2 + longint'(p) * lm;
    return int'(v % (longint'(24) * longint'(nzc)));
  endfunction

  task automatic start_seq(input string tag, input int nzc, input int q, input int p, input int len);
    bus.zc_N_zc = 11'(nzc);
    bus.zc_Q    = 15'(q);
    bus.zc_P    = 16'(p);
    bus.seq_len = 13'(len);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check({tag, " init_busy"}, 32'(bus.busy), 32'd1);
    check({tag, " init_valid"}, 32'(bus.ph_valid), 32'd0);
  endtask

  // mode 0: ready always high; 1: stall on RUN cycles 1 and 3; 2: random ready
  task automatic drain(input string tag, input int len, input int mode);
    int k = 0;
    int cyc = 0;
    logic rdy;
    tick();
    while (k < len && cyc < len * 8 + 50) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc == 1 || cyc == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.ph_ready = rdy;
      check({tag, " valid"}, 32'(bus.ph_valid), 32'd1);
      check({tag, " idx"}, 32'(bus.ph_idx), 32'(exp_q[k]));
      check({tag, " last"}, 32'(bus.ph_last), 32'(k == len - 1));
      if (rdy) k++;
      cyc++;
      tick();
    end
    bus.ph_ready = 1'b1;
    check({tag, " xfer_count"}, 32'(k), 32'(len));
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " done_valid"}, 32'(bus.ph_valid), 32'd0);
    tick();
    check({tag, " done_clear"}, 32'(bus.done), 32'd0);
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int nzc, q, p, len;
    bus.start    = 1'b0;
    bus.zc_Q     = '0;
    bus.zc_P     = '0;
    bus.zc_N_zc  = '0;
    bus.seq_len  = '0;
    bus.ph_ready = 1'b1;

    #12;
    check("rst valid", 32'(bus.ph_valid), 32'd0);
    check("rst last", 32'(bus.ph_last), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst idx", 32'(bus.ph_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Quadratic phase, no modular reduction needed
    exp_q = '{0, 12, 36, 72};
    start_seq("basic", 139, 12, 0, 4);
    drain("basic", 4, 0);

    // Both adders wrap modulo 3336
    exp_q = '{0, 266, 520};
    start_seq("modsub", 139, 3324, 278, 3);
    drain("modsub", 3, 0);

    // Period of 2 extended to 5 samples
    exp_q = '{0, 12, 0, 12, 0};
    start_seq("wrap", 2, 12, 0, 5);
    drain("wrap", 5, 0);

    exp_q = '{0, 12, 36, 72};
    start_seq("stall", 139, 12, 0, 4);
    drain("stall", 4, 1);

    exp_q = '{0};
    start_seq("len1", 139, 12, 0, 1);
    drain("len1", 1, 0);

    exp_q = '{0, 0, 0};
    start_seq("nzc1", 1, 12, 12, 3);
    drain("nzc1", 3, 0);

    // Restart attempts while busy, then abort via reset
    start_seq("abort", 139, 12, 0, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("abort idx0", 32'(bus.ph_idx), 32'd0);
    tick();
    check("abort idx1", 32'(bus.ph_idx), 32'd12);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("abort idx2", 32'(bus.ph_idx), 32'd36);
    check("abort busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort rst valid", 32'(bus.ph_valid), 32'd0);
    check("abort rst busy", 32'(bus.busy), 32'd0);
    check("abort rst done", 32'(bus.done), 32'd0);
    check("abort rst last", 32'(bus.ph_last), 32'd0);
    check("abort rst idx", 32'(bus.ph_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort no_done", 32'(bus.done), 32'd0);
    exp_q = '{0, 12, 36, 72};
    start_seq("fresh", 139, 12, 0, 4);
    drain("fresh", 4, 0);

    // Randomized configurations against the closed-form phase
    for (int r = 0; r < 3; r++) begin
      nzc = int'($urandom_range(1, 1365));
      q   = int'((12 * $urandom_range(0, 4095)) % (24 * nzc));
      p   = int'((2 * $urandom_range(0, 11) * nzc) % (24 * nzc));
      len = int'($urandom_range(1, 3300));
      exp_q.delete();
      for (int k = 0; k < len; k++) exp_q.push_back(zc_ph(nzc, q, p, k % nzc));
      start_seq("rand", nzc, q, p, len);
      drain("rand", len, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
